// File: rtl/fft_agu_pkg.sv
// Shared sizes, state encoding, address payload and index helpers for the in-place radix-2 FFT AGU.
package fft_pkg;

    localparam int unsigned N_2   = 5;
    localparam int unsigned N     = 1 << N_2;
    localparam int unsigned ADR_W = N_2;
    localparam int unsigned TW_W  = N_2 - 1;
    localparam int unsigned FLY_W = N_2 - 1;
    localparam int unsigned LVL_W = N_2;
    localparam int unsigned CNT_W = N_2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DONE
    } fft_agu_state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adra;
        logic [ADR_W-1:0] adrb;
        logic [TW_W-1:0]  twiddleadr;
    } fft_adr_t;

    function automatic logic [ADR_W-1:0] bitreverse(input logic [ADR_W-1:0] x);
        return {<<{x}};
    endfunction

    // Left rotate within ADR_W bits; sh is always below ADR_W at the call sites.
    function automatic logic [ADR_W-1:0] rotl(input logic [ADR_W-1:0] x,
                                              input logic [LVL_W-1:0] sh);
        logic [2*ADR_W-1:0] w_dbl;
        w_dbl = {x, x} << sh;
        return w_dbl[2*ADR_W-1 -: ADR_W];
    endfunction

endpackage

// File: rtl/fft_agu_if.sv
// Control/address bundle between the FFT sequencer and its host/datapath.
interface fft_agu_if;
    import fft_pkg::*;

    logic             start;
    logic             in_valid;
    logic [ADR_W-1:0] adra;
    logic [ADR_W-1:0] adrb;
    logic [TW_W-1:0]  twiddleadr;
    logic             we;
    logic             loading;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             done;

    modport master (
        output start, in_valid,
        input  adra, adrb, twiddleadr, we, loading, level, busy, done
    );

    modport slave (
        input  start, in_valid,
        output adra, adrb, twiddleadr, we, loading, level, busy, done
    );

endinterface

// File: rtl/fft_bfly_adr.sv
// Maps (level, butterfly index) to the RAM address pair and twiddle ROM address.
module fft_bfly_adr
    import fft_pkg::*;
(
    input  logic [LVL_W-1:0] i_lvl,
    input  logic [FLY_W-1:0] i_fly,
    output fft_adr_t         o_adr
);

    logic [ADR_W-1:0] w_pair;
    logic [LVL_W-1:0] w_sh;
    logic [TW_W-1:0]  w_keep;

    always_comb begin
        w_pair = {i_fly, 1'b0};
        // Clear the low (N_2-1-lvl) bits of fly; level 0 clears them all.
        w_sh   = LVL_W'(TW_W) - i_lvl;
        w_keep = {TW_W{1'b1}} << w_sh;

        o_adr.adra       = rotl(w_pair, i_lvl);
        o_adr.adrb       = rotl(w_pair | ADR_W'(1), i_lvl);
        o_adr.twiddleadr = i_fly & w_keep;
    end

endmodule

// File: rtl/fft_agu.sv
// Address generator and sequencer for an in-place radix-2 FFT, one butterfly per clock.
// Define FFT_AGU_LOAD_EN to add the bit-reversed sample LOAD phase driven by in_valid.
module fft_agu
    import fft_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    fft_agu_if.slave  bus
);

    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(N_2 - 1);
    localparam logic [FLY_W-1:0] FLY_LAST = FLY_W'(N / 2 - 1);

    fft_agu_state_t   r_state;
    logic [LVL_W-1:0] r_lvl;
    logic [FLY_W-1:0] r_fly;
    logic             r_busy;
    logic             r_done;
    fft_adr_t         w_adr;

`ifdef FFT_AGU_LOAD_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_loading;
    logic [ADR_W-1:0] w_brev;

    assign w_brev      = bitreverse(r_cnt);
    assign bus.loading = r_loading;
`else
    logic w_unused_in_valid;

    assign w_unused_in_valid = bus.in_valid;
    assign bus.loading       = 1'b0;
`endif

    // Sequencer: state, counters and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lvl     <= '0;
            r_fly     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef FFT_AGU_LOAD_EN
            r_cnt     <= '0;
            r_loading <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_lvl <= '0;
                    r_fly <= '0;
                    if (bus.start) begin
                        r_busy <= 1'b1;
`ifdef FFT_AGU_LOAD_EN
                        r_state   <= LOAD;
                        r_cnt     <= '0;
                        r_loading <= 1'b1;
`else
                        r_state   <= COMPUTE;
`endif
                    end
                end
`ifdef FFT_AGU_LOAD_EN
                LOAD: begin
                    if (bus.in_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state   <= COMPUTE;
                            r_loading <= 1'b0;
                        end
                    end
                end
`endif
                COMPUTE: begin
                    r_fly <= r_fly + FLY_W'(1);
                    if (r_fly == FLY_LAST) begin
                        if (r_lvl == LVL_LAST) begin
                            r_lvl   <= '0;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_lvl <= r_lvl + LVL_W'(1);
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    fft_bfly_adr u_bfly (
        .i_lvl (r_lvl),
        .i_fly (r_fly),
        .o_adr (w_adr)
    );

    // Memory-side decode; only LOAD's write enable follows an input directly.
    always_comb begin
        bus.adra       = '0;
        bus.adrb       = '0;
        bus.twiddleadr = '0;
        bus.we         = 1'b0;
        case (r_state)
`ifdef FFT_AGU_LOAD_EN
            LOAD: begin
                bus.adra = w_brev;
                bus.adrb = w_brev;
                bus.we   = bus.in_valid;
            end
`endif
            COMPUTE: begin
                bus.adra       = w_adr.adra;
                bus.adrb       = w_adr.adrb;
                bus.twiddleadr = w_adr.twiddleadr;
                bus.we         = 1'b1;
            end
            default: begin
                bus.we = 1'b0;
            end
        endcase
    end

    assign bus.level = r_lvl;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_fft_agu.sv
// Bench for fft_agu (N_2=5): address tables, abort on reset, randomized transforms checked
// against an arithmetic address model and a direct DFT. Honors FFT_AGU_LOAD_EN when defined.
`timescale 1ns/1ps
module tb_fft_agu;

    localparam int  NPT   = 32;
    localparam int  LV    = 5;
    localparam int  HALF  = NPT / 2;
    localparam int  NCOMP = LV * HALF;
    localparam real PI    = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_agu_if bus ();

    fft_agu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  n_vec = 0;
    int  n_err = 0;
    real ram_re [NPT];
    real ram_im [NPT];
    real x_re   [NPT];
    real x_im   [NPT];
    int  obs_a  [NCOMP];
    int  obs_b  [NCOMP];
    int  obs_t  [NCOMP];

    typedef struct {
        int lvl;
        int fly;
        int adra;
        int adrb;
        int tw;
    } adr_vec_t;

    adr_vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs packed together; zero means fully idle.
    function automatic int outs_all();
        return int'({bus.adra, bus.adrb, bus.twiddleadr, bus.we, bus.loading,
                     bus.level, bus.busy, bus.done});
    endfunction

    function automatic int ref_rotl(input int x, input int s);
        return ((x << s) | (x >> (LV - s))) & (NPT - 1);
    endfunction

    function automatic int ref_brev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < LV; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    function automatic int ref_tw(input int fly, input int lvl);
        return (fly >> (LV - 1 - lvl)) << (LV - 1 - lvl);
    endfunction

    // Radix-2 DIT butterfly on the bench RAM with twiddle W_N^tw.
    task automatic bfly(input int a, input int b, input int tw);
        real wr, wi, br, bi;
        wr = $cos(2.0 * PI * tw / NPT);
        wi = -$sin(2.0 * PI * tw / NPT);
        br = ram_re[b] * wr - ram_im[b] * wi;
        bi = ram_re[b] * wi + ram_im[b] * wr;
        ram_re[b] = ram_re[a] - br;
        ram_im[b] = ram_im[a] - bi;
        ram_re[a] = ram_re[a] + br;
        ram_im[a] = ram_im[a] + bi;
    endtask

    task automatic chk_dft(input string nm);
        real er, ei, ang, err;
        for (int k = 0; k < NPT; k++) begin
            er = 0.0;
            ei = 0.0;
            for (int n = 0; n < NPT; n++) begin
                ang = -2.0 * PI * k * n / NPT;
                er  = er + x_re[n] * $cos(ang) - x_im[n] * $sin(ang);
                ei  = ei + x_re[n] * $sin(ang) + x_im[n] * $cos(ang);
            end
            err = (ram_re[k] - er) * (ram_re[k] - er) + (ram_im[k] - ei) * (ram_im[k] - ei);
            chk($sformatf("%s bin %0d within tolerance", nm, k), (err < 1.0e-9) ? 1 : 0, 1);
        end
    endtask

    task automatic run_fft(input string nm, input bit impulse);
        int lvl, fly, acc, guard;
        for (int i = 0; i < NPT; i++) begin
            x_re[i]   = impulse ? ((i == 0) ? 1.0 : 0.0)
                                : real'(int'($urandom_range(0, 200)) - 100) / 16.0;
            x_im[i]   = impulse ? 0.0 : real'(int'($urandom_range(0, 200)) - 100) / 16.0;
            ram_re[i] = 0.0;
            ram_im[i] = 0.0;
        end
`ifndef FFT_AGU_LOAD_EN
        for (int i = 0; i < NPT; i++) begin
            ram_re[ref_brev(i)] = x_re[i];
            ram_im[ref_brev(i)] = x_im[i];
        end
`endif
        repeat ($urandom_range(0, 3)) begin
            step();
            chk({nm, " idle before start"}, outs_all(), 0);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
`ifdef FFT_AGU_LOAD_EN
        acc   = 0;
        guard = 0;
        while (acc < NPT && guard < 400) begin
            bus.in_valid = impulse ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
            bus.start    = 1'($urandom_range(0, 1));
            #1;
            chk({nm, " load loading/busy/done"}, int'({bus.loading, bus.busy, bus.done}), 6);
            chk({nm, " load we"}, int'(bus.we), int'(bus.in_valid));
            chk({nm, " load adra"}, int'(bus.adra), ref_brev(acc));
            chk({nm, " load adrb"}, int'(bus.adrb), ref_brev(acc));
            if (acc == 1) chk({nm, " load cnt1 adra"}, int'(bus.adra), 16);
            if (acc == 6) chk({nm, " load cnt6 adra"}, int'(bus.adra), 12);
            if (bus.we) begin
                ram_re[int'(bus.adra)] = x_re[acc];
                ram_im[int'(bus.adra)] = x_im[acc];
            end
            if (bus.in_valid) acc++;
            step();
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk({nm, " load accepted count"}, acc, NPT);
`endif
        for (int c = 0; c < NCOMP; c++) begin
            lvl       = c / HALF;
            fly       = c % HALF;
            bus.start = 1'($urandom_range(0, 1));
            chk({nm, " compute busy/done/loading"}, int'({bus.busy, bus.done, bus.loading}), 4);
            chk({nm, " compute we"}, int'(bus.we), 1);
            chk({nm, " compute level"}, int'(bus.level), lvl);
            chk({nm, " compute adra"}, int'(bus.adra), ref_rotl(2 * fly, lvl));
            chk({nm, " compute adrb"}, int'(bus.adrb), ref_rotl(2 * fly + 1, lvl));
            chk({nm, " compute twiddle"}, int'(bus.twiddleadr), ref_tw(fly, lvl));
            obs_a[c] = int'(bus.adra);
            obs_b[c] = int'(bus.adrb);
            obs_t[c] = int'(bus.twiddleadr);
            if (bus.we) bfly(int'(bus.adra), int'(bus.adrb), int'(bus.twiddleadr));
            step();
        end
        bus.start = 1'b1;
        chk({nm, " done/busy/we in DONE"}, int'({bus.done, bus.busy, bus.we}), 4);
        chk({nm, " addresses zero in DONE"}, int'({bus.adra, bus.adrb, bus.twiddleadr}), 0);
        step();
        bus.start = 1'b0;
        chk({nm, " idle after DONE"}, outs_all(), 0);
        step();
        chk({nm, " still idle after DONE start"}, outs_all(), 0);
        chk_dft(nm);
    endtask

    initial begin
        int c, done_seen;

        tbl[0] = '{lvl: 1, fly: 3,  adra: 12, adrb: 14, tw: 0};
        tbl[1] = '{lvl: 2, fly: 5,  adra: 9,  adrb: 13, tw: 4};
        tbl[2] = '{lvl: 4, fly: 15, adra: 15, adrb: 31, tw: 15};
        tbl[3] = '{lvl: 0, fly: 0,  adra: 0,  adrb: 1,  tw: 0};
        tbl[4] = '{lvl: 3, fly: 7,  adra: 19, adrb: 27, tw: 6};
        tbl[5] = '{lvl: 0, fly: 9,  adra: 18, adrb: 19, tw: 0};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset outputs", outs_all(), 0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            step();
            chk("idle outputs", outs_all(), 0);
        end
        bus.in_valid = 1'b0;

        run_fft("impulse", 1'b1);
        for (int i = 0; i < 6; i++) begin
            c = tbl[i].lvl * HALF + tbl[i].fly;
            chk($sformatf("table %0d adra", i), obs_a[c], tbl[i].adra);
            chk($sformatf("table %0d adrb", i), obs_b[c], tbl[i].adrb);
            chk($sformatf("table %0d twiddle", i), obs_t[c], tbl[i].tw);
        end

        // Reset in the middle of COMPUTE aborts without a done pulse.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
`ifdef FFT_AGU_LOAD_EN
        bus.in_valid = 1'b1;
        repeat (NPT) step();
        bus.in_valid = 1'b0;
`endif
        repeat (20) step();
        chk("abort precondition busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort busy/we/done", int'({bus.busy, bus.we, bus.done}), 0);
        chk("abort all outputs", outs_all(), 0);
        done_seen = 0;
        repeat (100) begin
            step();
            if (bus.done) done_seen++;
        end
        chk("abort no done pulse", done_seen, 0);
        chk("abort stays idle", outs_all(), 0);

        for (int r = 0; r < 3; r++) run_fft($sformatf("random%0d", r), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
